// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// Holds the bus widths, the load state encoding and the bit positions of the
// execute->memory bus fields.
package mem_stage_pkg;

  localparam int unsigned ES_TO_MS_BUS_WD = 77;
  // The writeback field list {dest_valid, gr_we, dest[4:0], final_result, pc}
  // needs 71 bits, so the bus is sized from the fields to keep dest_valid.
  localparam int unsigned MS_TO_WS_BUS_WD = 71;
  localparam int unsigned FW_WD           = 39;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHave = 2'd2
  } ms_state_e;

  // Execute->memory bus field positions.
  localparam int unsigned BusPcLsb      = 0;
  localparam int unsigned BusResultLsb  = 32;
  localparam int unsigned BusDestLsb    = 64;
  localparam int unsigned BusGrWe       = 69;
  localparam int unsigned BusResFromMem = 70;
  localparam int unsigned BusDestValid  = 71;
  localparam int unsigned BusLw         = 72;
  localparam int unsigned BusLb         = 73;
  localparam int unsigned BusLbu        = 74;
  localparam int unsigned BusLh         = 75;
  localparam int unsigned BusLhu        = 76;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   rdata_i  raw 32-bit load word
//   addr_i   low two address bits of the access
//   lb_i/lbu_i/lh_i/lhu_i/lw_i  one-hot load type
//   data_o   aligned, extended result (0 when no load type is set)
module mem_stage_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic        lb_i,
  input  logic        lbu_i,
  input  logic        lh_i,
  input  logic        lhu_i,
  input  logic        lw_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (addr_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
  end

  // addr_i[0] is ignored for halfwords: no misalignment trapping here.
  assign half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = '0;
    if (lb_i) begin
      data_o = {{24{byte_sel[7]}}, byte_sel};
    end else if (lbu_i) begin
      data_o = {24'd0, byte_sel};
    end else if (lh_i) begin
      data_o = {{16{half_sel[15]}}, half_sel};
    end else if (lhu_i) begin
      data_o = {16'd0, half_sel};
    end else if (lw_i) begin
      data_o = rdata_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and writeback.
// Latches the execute->memory bus, waits for a possibly delayed data-SRAM load
// response, aligns/extends load data and hands the result to writeback. Also
// drives a forwarding bus to decode with a load-pending flag for load-use
// stalls.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   es_to_ms_valid/es_to_ms_bus      incoming instruction from execute
//   ms_allowin                       this stage can accept this cycle
//   ws_allowin                       writeback can accept this cycle
//   ms_to_ws_valid/ms_to_ws_bus      outgoing instruction to writeback
//   data_sram_rdata/data_sram_rvalid load response
//   ms_to_ds_fw                      {load_pending, fw_valid, dest, final_result}
module mem_stage import mem_stage_pkg::*; (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       data_sram_rvalid,
  output logic [FW_WD-1:0]           ms_to_ds_fw
);

  logic                       ms_valid_q;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q;
  ms_state_e                  state_q;
  logic [31:0]                rdata_buf_q;

  logic        ms_ready_go;
  logic        res_from_mem;
  logic [31:0] result;
  logic [4:0]  dest;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        ms_load_pending;
  logic        fw_valid;

  assign res_from_mem = bus_q[BusResFromMem];
  assign result       = bus_q[BusResultLsb +: 32];
  assign dest         = bus_q[BusDestLsb +: 5];

  // A load is ready on the cycle its response arrives, or once buffered.
  assign ms_ready_go = !res_from_mem
                     || (state_q == StWait && data_sram_rvalid)
                     || (state_q == StHave);

  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      state_q     <= StIdle;
      rdata_buf_q <= 32'd0;
    end else if (ms_allowin) begin
      ms_valid_q <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        bus_q <= es_to_ms_bus;
      end
      state_q <= (es_to_ms_valid && es_to_ms_bus[BusResFromMem]) ? StWait : StIdle;
    end else if (state_q == StWait && data_sram_rvalid) begin
      // Stalled by writeback: park the response until it can leave.
      state_q     <= StHave;
      rdata_buf_q <= data_sram_rdata;
    end
  end

  assign load_word = (state_q == StHave) ? rdata_buf_q : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .rdata_i (load_word),
    .addr_i  (result[1:0]),
    .lb_i    (bus_q[BusLb]),
    .lbu_i   (bus_q[BusLbu]),
    .lh_i    (bus_q[BusLh]),
    .lhu_i   (bus_q[BusLhu]),
    .lw_i    (bus_q[BusLw]),
    .data_o  (load_data)
  );

  assign final_result = res_from_mem ? load_data : result;

  assign ms_to_ws_bus = {bus_q[BusDestValid], bus_q[BusGrWe], dest, final_result,
                         bus_q[BusPcLsb +: 32]};

  assign ms_load_pending = ms_valid_q && res_from_mem && !ms_ready_go;
  assign fw_valid        = ms_valid_q && bus_q[BusDestValid];
  assign ms_to_ds_fw     = {ms_load_pending, fw_valid, dest, final_result};

endmodule
